// File: rtl/ifetch_queue.sv
// Fetch-to-decode instruction queue: in-order FIFO of instr/PC pairs with first-word fall-through.
// Optional same-cycle fetch-to-decode bypass when empty: define IFETCH_QUEUE_BYPASS_EN.
module ifetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush_i,
  input  logic             if_valid_i,
  input  logic [31:0]      if_instr_i,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             if_ready_o,
  output logic             dec_valid_o,
  output logic [31:0]      dec_instr_o,
  output logic [XLEN-1:0]  dec_pc_o,
  input  logic             dec_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   full, empty, push, pop, wr_en, rd_en;
  logic   bypass, bypass_take;
  entry_t head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

`ifdef IFETCH_QUEUE_BYPASS_EN
  // Reset gates the bypass so outputs read idle while reset_n is low.
  assign bypass = reset_n & empty & if_valid_i & ~flush_i;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    head = mem_q[rd_ptr_q];
    if (bypass) head = '{instr: if_instr_i, pc: if_pc_i};
  end

  assign dec_valid_o = ~empty | bypass;
  assign dec_instr_o = {32{dec_valid_o}} & head.instr;
  assign dec_pc_o    = {XLEN{dec_valid_o}} & head.pc;
  assign if_ready_o  = ~full;
  assign full_o      = full;
  assign empty_o     = empty;
  assign count_o     = count_q;

  assign push        = if_valid_i & ~full & ~flush_i;
  assign pop         = dec_valid_o & dec_ready_i & ~flush_i;
  // A bypassed pair consumed in the same cycle never touches storage or pointers.
  assign bypass_take = bypass & dec_ready_i;
  assign wr_en       = push & ~bypass_take;
  assign rd_en       = pop & ~bypass_take;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
      else if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; count gating dec_valid_o keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{instr: if_instr_i, pc: if_pc_i};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (count_q <= CNT_W'(DEPTH))
        else $error("ifetch_queue: count %0d exceeds depth", count_q);
      assert (!(rd_en && empty))
        else $error("ifetch_queue: pop while empty");
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_ifetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush_i = 1'b0;
  logic             if_valid_i = 1'b0;
  logic [31:0]      if_instr_i = '0;
  logic [XLEN-1:0]  if_pc_i = '0;
  logic             dec_ready_i = 1'b0;
  logic             if_ready_o, dec_valid_o, full_o, empty_o;
  logic [31:0]      dec_instr_o;
  logic [XLEN-1:0]  dec_pc_o;
  logic [CNT_W-1:0] count_o;

  ifetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .if_valid_i  (if_valid_i),
    .if_instr_i  (if_instr_i),
    .if_pc_i     (if_pc_i),
    .if_ready_o  (if_ready_o),
    .dec_valid_o (dec_valid_o),
    .dec_instr_o (dec_instr_o),
    .dec_pc_o    (dec_pc_o),
    .dec_ready_i (dec_ready_i),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } pair_t;

  pair_t model_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
  endtask

  function automatic bit model_bypass();
`ifdef IFETCH_QUEUE_BYPASS_EN
    return reset_n && model_q.size() == 0 && if_valid_i && !flush_i;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    bit              bp;
    bit              exp_valid;
    logic [31:0]     ei;
    logic [XLEN-1:0] ep;
    bp        = model_bypass();
    exp_valid = bp || (model_q.size() > 0);
    ei = '0;
    ep = '0;
    if (bp) begin
      ei = if_instr_i;
      ep = if_pc_i;
    end else if (model_q.size() > 0) begin
      ei = model_q[0].instr;
      ep = model_q[0].pc;
    end
    check("dec_valid", 64'(dec_valid_o), 64'(exp_valid));
    check("dec_instr", 64'(dec_instr_o), 64'(ei));
    check("dec_pc",    64'(dec_pc_o),    64'(ep));
    check("count",     64'(count_o),     64'(model_q.size()));
    check("full",      64'(full_o),      64'(model_q.size() == DEPTH));
    check("empty",     64'(empty_o),     64'(model_q.size() == 0));
    check("if_ready",  64'(if_ready_o),  64'(model_q.size() != DEPTH));
  endtask

  // Inputs change at the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    bit bp, valid, push, pop;
    #1;
    check_outputs();
    if (flush_i) begin
      model_q.delete();
    end else begin
      bp    = model_bypass();
      valid = bp || (model_q.size() > 0);
      push  = if_valid_i && (model_q.size() != DEPTH);
      pop   = valid && dec_ready_i;
      if (push) model_q.push_back('{instr: if_instr_i, pc: if_pc_i});
      if (pop)  void'(model_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    if_valid_i  = v;
    if_instr_i  = instr;
    if_pc_i     = pc;
    dec_ready_i = rdy;
    flush_i     = fl;
  endtask

  logic [31:0] t2_instr [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};
  logic [31:0] t2_pc    [4] = '{32'h80000000, 32'h80000004, 32'h80000008, 32'h8000000C};

  initial begin
    // Power-on reset
    #1;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // T2: fill to full with decode stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t2_instr[i], t2_pc[i], 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h0BAD0BAD, 32'h80000FF0, 1'b0, 1'b0);
    #1;
    check("t2_full", 64'(full_o), 64'd1);
    check("t2_if_ready", 64'(if_ready_o), 64'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #1;
      check("t2_order_pc", 64'(dec_pc_o), 64'(t2_pc[i]));
      check("t2_order_instr", 64'(dec_instr_o), 64'(t2_instr[i]));
      step();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("t2_empty", 64'(empty_o), 64'd1);
    step();

    // T3: wrap-around at steady occupancy 2
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 32'h80001000 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    for (int i = 2; i < 12; i++) begin
      drive(1'b1, $urandom, 32'h80001000 + 32'(4 * i), 1'b1, 1'b0);
      #1;
      check("t3_count", 64'(count_o), 64'd2);
      step();
    end

    // T1: asynchronous reset mid-stream with three entries held
    drive(1'b1, $urandom, 32'h80002000, 1'b0, 1'b0);
    step();
    drive(1'b1, $urandom, 32'h80002004, 1'b0, 1'b0);
    #1;
    check("t1_pre_count", 64'(count_o), 64'd3);
    reset_n = 1'b0;
    #1;
    model_q.delete();
    check("t1_count", 64'(count_o), 64'd0);
    check("t1_empty", 64'(empty_o), 64'd1);
    check("t1_valid", 64'(dec_valid_o), 64'd0);
    check("t1_instr", 64'(dec_instr_o), 64'd0);
    check("t1_pc", 64'(dec_pc_o), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();

    // T4: flush with a push attempted in the flush cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 32'h80003000 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'hDEADBEEF, 32'h80003F00, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      #1;
      check("t4_count", 64'(count_o), 64'd0);
      check("t4_valid", 64'(dec_valid_o), 64'd0);
      step();
    end

    // T5: head held stable under back-pressure
    drive(1'b1, 32'h00A00513, 32'h80000010, 1'b0, 1'b0);
    step();
    drive(1'b1, $urandom, 32'h80000014, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      check("t5_hold_pc", 64'(dec_pc_o), 64'h80000010);
      check("t5_hold_instr", 64'(dec_instr_o), 64'h00A00513);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
    end

    // T6: fetch into an empty queue with decode ready
    drive(1'b1, 32'h00500293, 32'h80000020, 1'b1, 1'b0);
    #1;
`ifdef IFETCH_QUEUE_BYPASS_EN
    check("t6_bypass_valid", 64'(dec_valid_o), 64'd1);
    check("t6_bypass_pc", 64'(dec_pc_o), 64'h80000020);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    check("t6_bypass_count", 64'(count_o), 64'd0);
    step();
`else
    check("t6_latency_valid0", 64'(dec_valid_o), 64'd0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    check("t6_latency_valid1", 64'(dec_valid_o), 64'd1);
    check("t6_latency_pc", 64'(dec_pc_o), 64'h80000020);
    step();
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
